// File: rtl/regfile_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_pkg
// Description : Shared constants, FSM state and beat type for the regfile
//               dump reader.
// Revision    : 1.0
// ============================================================================
package regfile_dump_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEND  = 3'd2,
        CHK   = 3'd3,
        DONE  = 3'd4
    } dump_state_e;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            last;
        logic            chk;
    } dump_beat_t;

endpackage
`default_nettype wire

// File: rtl/regfile_dump_ptr.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_ptr
// Description : Wrap-around register pointer with load, increment and an
//               end-of-range compare.
// Revision    : 1.0
// ============================================================================
module regfile_dump_ptr
    import regfile_dump_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          i_load,
    input  logic [AW-1:0] i_first,
    input  logic [AW-1:0] i_last,
    input  logic          i_inc,
    output logic [AW-1:0] o_ptr,
    output logic          o_at_end
);

    logic [AW-1:0] r_ptr;
    logic [AW-1:0] r_end;

    // Increment is modulo NREG by virtue of the AW-bit width.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ptr <= '0;
            r_end <= '0;
        end else if (i_load) begin
            r_ptr <= i_first;
            r_end <= i_last;
        end else if (i_inc) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign o_ptr    = r_ptr;
    assign o_at_end = (r_ptr == r_end);

endmodule
`default_nettype wire

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_reader
// Description : Walks a register range through a spare regfile read port and
//               streams (addr, data) beats on a valid/ready interface.
//               Optional trailing XOR checksum beat: DUMP_CHECKSUM_EN.
// Revision    : 1.0
// ============================================================================
module regfile_dump_reader
    import regfile_dump_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [AW-1:0]   first_addr_i,
    input  logic [AW-1:0]   last_addr_i,
    output logic [AW-1:0]   rf_raddr_o,
    input  logic [XLEN-1:0] rf_rdata_i,
    output logic            dump_valid_o,
    input  logic            dump_ready_i,
    output logic [AW-1:0]   dump_addr_o,
    output logic [XLEN-1:0] dump_data_o,
    output logic            dump_last_o,
    output logic            dump_chk_o,
    output logic            busy_o,
    output logic            done_o
);

`ifdef DUMP_CHECKSUM_EN
    localparam bit c_chk_en = 1'b1;
`else
    localparam bit c_chk_en = 1'b0;
`endif

    dump_state_e     r_state;
    dump_state_e     w_next;
    dump_beat_t      r_beat;
    logic [XLEN-1:0] r_xor;
    logic [AW-1:0]   w_ptr;
    logic            w_at_end;
    logic            w_load;
    logic            w_inc;
    logic            w_accept;
    logic            w_valid;
    logic            w_busy;
    logic            w_done;
    logic [AW-1:0]   w_raddr;

    assign w_load   = (r_state == IDLE) && start_i && !abort_i;
    assign w_accept = w_valid && dump_ready_i && !abort_i;
    assign w_inc    = (r_state == SEND) && w_accept && !w_at_end;

    regfile_dump_ptr u_ptr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_load   (w_load),
        .i_first  (first_addr_i),
        .i_last   (last_addr_i),
        .i_inc    (w_inc),
        .o_ptr    (w_ptr),
        .o_at_end (w_at_end)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (abort_i && (r_state != IDLE)) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start_i) w_next = FETCH;
                FETCH:   w_next = SEND;
                SEND:    if (w_accept) w_next = w_at_end ? (c_chk_en ? CHK : DONE) : FETCH;
                CHK:     if (w_accept) w_next = DONE;
                DONE:    w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_valid = 1'b0;
        w_busy  = 1'b1;
        w_done  = 1'b0;
        w_raddr = '0;
        case (r_state)
            IDLE:    w_busy  = 1'b0;
            FETCH:   w_raddr = w_ptr;
            SEND:    w_valid = 1'b1;
            CHK:     w_valid = 1'b1;
            DONE:    w_done  = 1'b1;
            default: w_busy  = 1'b0;
        endcase
    end

    // With the checksum enabled, only the trailing checksum beat carries last.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_beat <= '0;
            r_xor  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load) r_xor <= '0;
                end
                FETCH: begin
                    r_beat.addr <= w_ptr;
                    r_beat.data <= rf_rdata_i;
                    r_beat.last <= w_at_end & ~c_chk_en;
                    r_beat.chk  <= 1'b0;
                end
                SEND: begin
                    if (w_accept) begin
                        r_xor <= r_xor ^ r_beat.data;
                        if (w_at_end && c_chk_en) begin
                            r_beat.addr <= '0;
                            r_beat.data <= r_xor ^ r_beat.data;
                            r_beat.last <= 1'b1;
                            r_beat.chk  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rf_raddr_o   = w_raddr;
    assign dump_valid_o = w_valid;
    assign busy_o       = w_busy;
    assign done_o       = w_done;
    assign dump_addr_o  = r_beat.addr;
    assign dump_data_o  = r_beat.data;
    assign dump_last_o  = r_beat.last;
    assign dump_chk_o   = c_chk_en ? r_beat.chk : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_dump_reader
// Description : Scoreboard bench for regfile_dump_reader.
// Revision    : 1.0
// ============================================================================
module tb_regfile_dump_reader;

`ifdef DUMP_CHECKSUM_EN
    localparam int c_extra = 1;
`else
    localparam int c_extra = 0;
`endif

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
        logic        chk;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic        abort_i;
    logic [4:0]  first_addr_i;
    logic [4:0]  last_addr_i;
    logic [4:0]  rf_raddr_o;
    logic [31:0] rf_rdata_i;
    logic        dump_valid_o;
    logic        dump_ready_i;
    logic [4:0]  dump_addr_o;
    logic [31:0] dump_data_o;
    logic        dump_last_o;
    logic        dump_chk_o;
    logic        busy_o;
    logic        done_o;

    logic [31:0] rf [32];
    exp_t        sb_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_acc    = 0;
    logic        r_hold   = 1'b0;
    logic [36:0] r_held;

    always #5 clk_i = ~clk_i;
    assign rf_rdata_i = rf[rf_raddr_o];

    regfile_dump_reader dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .first_addr_i (first_addr_i),
        .last_addr_i  (last_addr_i),
        .rf_raddr_o   (rf_raddr_o),
        .rf_rdata_i   (rf_rdata_i),
        .dump_valid_o (dump_valid_o),
        .dump_ready_i (dump_ready_i),
        .dump_addr_o  (dump_addr_o),
        .dump_data_o  (dump_data_o),
        .dump_last_o  (dump_last_o),
        .dump_chk_o   (dump_chk_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int a, input logic [31:0] d, input logic l, input logic c);
        exp_t e;
        e.addr = 5'(a);
        e.data = d;
        e.last = l;
        e.chk  = c;
        sb_q.push_back(e);
    endtask

    // Push the register beats of a range plus, when enabled, the checksum beat.
    task automatic push_range(input int f, input int n);
        logic [31:0] x;
        int a;
        x = '0;
        for (int k = 0; k < n; k++) begin
            a = (f + k) % 32;
            x = x ^ rf[a];
            push(a, rf[a], (k == n - 1) && (c_extra == 0), 1'b0);
        end
        if (c_extra == 1) push(0, x, 1'b1, 1'b1);
    endtask

    // Monitor: pops and compares on every accepted beat, checks hold stability.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            r_hold <= 1'b0;
        end else begin
            if (r_hold && dump_valid_o)
                chk("hold_stable", {27'd0, dump_addr_o, dump_data_o}, {27'd0, r_held});
            r_hold <= dump_valid_o && !dump_ready_i && !abort_i;
            r_held <= {dump_addr_o, dump_data_o};
            if (dump_valid_o && dump_ready_i && !abort_i) begin
                n_acc++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_beat: got addr %0h data %0h, scoreboard empty",
                             dump_addr_o, dump_data_o);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("beat", {25'd0, dump_addr_o, dump_data_o, dump_last_o, dump_chk_o},
                        {25'd0, e});
                end
            end
        end
    end

    task automatic run_dump(input int f, input int l, input bit rnd, input int exp_cyc);
        int c;
        start_i      = 1'b1;
        first_addr_i = 5'(f);
        last_addr_i  = 5'(l);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        c = 0;
        while (!done_o && c < 400) begin
            if (rnd) dump_ready_i = 1'($urandom_range(0, 1));
            @(posedge clk_i); #1;
            c++;
        end
        chk("done_seen", {63'd0, done_o}, 64'd1);
        if (exp_cyc >= 0) chk("latency", 64'(c), 64'(exp_cyc));
        dump_ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("done_pulse_end", {62'd0, done_o, busy_o}, 64'd0);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic start_pulse(input int f, input int l);
        start_i      = 1'b1;
        first_addr_i = 5'(f);
        last_addr_i  = 5'(l);
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_valid();
        int c;
        c = 0;
        while (!dump_valid_o && c < 20) begin
            @(posedge clk_i); #1;
            c++;
        end
        chk("valid_seen", {63'd0, dump_valid_o}, 64'd1);
    endtask

    task automatic accept_one();
        wait_valid();
        dump_ready_i = 1'b1;
        @(posedge clk_i); #1;
        dump_ready_i = 1'b0;
    endtask

    function automatic logic [63:0] all_outs();
        return {17'd0, dump_valid_o, dump_last_o, dump_chk_o, busy_o, done_o,
                dump_addr_o, dump_data_o, rf_raddr_o};
    endfunction

    initial begin
        int a0;
        int done_seen;
        rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; dump_ready_i = 1'b1;
        first_addr_i = '0; last_addr_i = '0;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h1111_1111;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_outputs", all_outs(), 64'd0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Full range, ready held high
        push_range(0, 32);
        run_dump(0, 31, 1'b0, 64 + c_extra);

        // Wrap range 30..1
        push_range(30, 4);
        run_dump(30, 1, 1'b0, 8 + c_extra);

        // Single beat
        push_range(17, 1);
        run_dump(17, 17, 1'b0, 2 + c_extra);

        // Backpressure on 5..7
        a0 = n_acc;
        push_range(5, 3);
        run_dump(5, 7, 1'b1, -1);
        chk("bp_beats", 64'(n_acc - a0), 64'(3 + c_extra));

        // Abort on beat 2 of 0..31 while ready low
        dump_ready_i = 1'b0;
        push(0, rf[0], 1'b0, 1'b0);
        push(1, rf[1], 1'b0, 1'b0);
        start_pulse(0, 31);
        accept_one();
        accept_one();
        wait_valid();
        chk("abort_beat_addr", 64'(dump_addr_o), 64'd2);
        abort_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        chk("abort_outs", {61'd0, dump_valid_o, busy_o, done_o}, 64'd0);
        done_seen = 0;
        repeat (4) begin
            @(posedge clk_i); #1;
            if (done_o || busy_o) done_seen++;
        end
        chk("abort_quiet", 64'(done_seen), 64'd0);
        chk("abort_sb", 64'(sb_q.size()), 64'd0);
        dump_ready_i = 1'b1;
        push_range(9, 2);
        run_dump(9, 10, 1'b0, 4 + c_extra);

        // Reset during FETCH with a simultaneous start
        dump_ready_i = 1'b0;
        start_pulse(0, 31);
        chk("pre_rst_busy", {63'd0, busy_o}, 64'd1);
        rst_ni = 1'b0; start_i = 1'b1; first_addr_i = 5'd3; last_addr_i = 5'd3;
        @(posedge clk_i); #1;
        chk("midrst_outputs", all_outs(), 64'd0);
        rst_ni = 1'b1; start_i = 1'b0;
        @(posedge clk_i); #1;
        chk("post_rst_idle", {62'd0, busy_o, dump_valid_o}, 64'd0);
        dump_ready_i = 1'b1;

        // Checksum range 3..4
        rf[3] = 32'hA5A5_A5A5;
        rf[4] = 32'h0F0F_0F0F;
        push(3, 32'hA5A5_A5A5, 1'b0 ^ (c_extra == 0 ? 1'b0 : 1'b0), 1'b0);
        push(4, 32'h0F0F_0F0F, (c_extra == 0), 1'b0);
        if (c_extra == 1) push(0, 32'hAAAA_AAAA, 1'b1, 1'b1);
        run_dump(3, 4, 1'b0, 4 + c_extra);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
